audio_ram_sequencer: RTL and testbench

Sequences audio sample traffic between the codec sample stream and the DDR RAM interface for the audio recorder. It accepts transport commands (play, record, pause, delete, delete_all) from the PicoBlaze output-port decode and paces one RAM transaction per codec sample. It also tracks record/playback pointers and recording length, and reports status back to a PicoBlaze input port. It replaces ad-hoc RAM sequencing in the top level and sits between `sockit_top`, `mem_interface` and the PicoBlaze port logic.

---
 rtl/audio_ram_sequencer.sv | 220 ++++++++++++++++++++++
 tb/tb_audio_ram_sequencer.sv | 488 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/audio_ram_sequencer.sv
// audio_ram_sequencer: paces one DDR RAM transaction per codec sample,
// runs PicoBlaze transport commands and reports recorder status.
module audio_ram_sequencer #(
    parameter int ADDR_W = 26,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [2:0]        cmd,
    input  logic              sample_end,
    input  logic [DATA_W-1:0] adc_sample,
    output logic [DATA_W-1:0] dac_sample,
    input  logic [ADDR_W-1:0] max_ram_address,
    input  logic              ram_rdy,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    output logic              ram_rd_req,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_data_present,
    output logic              ram_rd_ack,
    output logic [7:0]        status
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REC_WAIT  = 3'd1,
        S_REC_WRITE = 3'd2,
        S_PLAY_WAIT = 3'd3,
        S_PLAY_REQ  = 3'd4,
        S_PLAY_DATA = 3'd5,
        S_PAUSE     = 3'd6,
        S_ERASE     = 3'd7
    } state_t;

    localparam logic [2:0] C_PLAY  = 3'd0;
    localparam logic [2:0] C_REC   = 3'd1;
    localparam logic [2:0] C_DEL   = 3'd2;
    localparam logic [2:0] C_PAUSE = 3'd3;
    localparam logic [2:0] C_DALL  = 3'd4;
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            state, state_d, resume_mode;
    logic [ADDR_W-1:0] wr_ptr, rd_ptr, end_addr;
    logic [2:0]        pend_cmd;
    logic              pend_valid;
    logic              overrun, full, done;

    logic       accepting, cmd_ok, eff_valid;
    logic [2:0] eff_cmd;
    logic       pend_set;
    logic       do_play, do_play_res, do_rec, do_del;
    logic       do_erase, do_pause, do_resume;
    logic       wr_last, rd_last;

    // A fresh command beats a latched one; both act only in accepting states.
    always_comb begin
        accepting = (state == S_IDLE) || (state == S_REC_WAIT) ||
                    (state == S_PLAY_WAIT) || (state == S_PAUSE);
        cmd_ok    = cmd_valid && (cmd <= C_DALL);
        eff_valid = accepting && (cmd_ok || pend_valid);
        eff_cmd   = cmd_ok ? cmd : pend_cmd;
        pend_set  = cmd_ok && !accepting && (state != S_ERASE);

        do_play     = eff_valid && (eff_cmd == C_PLAY) && (state != S_PAUSE);
        do_play_res = eff_valid && (eff_cmd == C_PLAY) && (state == S_PAUSE);
        do_rec      = eff_valid && (eff_cmd == C_REC);
        do_del      = eff_valid && (eff_cmd == C_DEL);
        do_erase    = eff_valid && (eff_cmd == C_DALL);
        do_pause    = eff_valid && (eff_cmd == C_PAUSE) &&
                      ((state == S_REC_WAIT) || (state == S_PLAY_WAIT));
        do_resume   = eff_valid && (eff_cmd == C_PAUSE) && (state == S_PAUSE);

        wr_last = (wr_ptr == max_ram_address);
        rd_last = (rd_ptr == end_addr);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        unique case (1'b1)
            do_play, do_play_res: state_d = S_PLAY_WAIT;
            do_rec:               state_d = S_REC_WAIT;
            do_del:               state_d = S_IDLE;
            do_erase:             state_d = S_ERASE;
            do_pause:             state_d = S_PAUSE;
            do_resume:            state_d = resume_mode;
            default: begin
                case (state)
                    S_REC_WAIT:
                        if (sample_end) state_d = S_REC_WRITE;
                    S_REC_WRITE:
                        if (ram_rdy) state_d = wr_last ? S_IDLE : S_REC_WAIT;
                    S_PLAY_WAIT:
                        if (sample_end) state_d = rd_last ? S_IDLE : S_PLAY_REQ;
                    S_PLAY_REQ:
                        if (ram_rdy) state_d = S_PLAY_DATA;
                    S_PLAY_DATA:
                        if (ram_data_present) state_d = S_PLAY_WAIT;
                    S_ERASE:
                        if (ram_rdy && wr_last) state_d = S_IDLE;
                    default: ;
                endcase
            end
        endcase
    end

    always_comb begin
        status = {overrun, full, done,
                  (state != S_IDLE) && (state != S_PAUSE),
                  (state == S_PAUSE), state};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            end_addr    <= '0;
            pend_cmd    <= '0;
            pend_valid  <= 1'b0;
            resume_mode <= S_IDLE;
            overrun     <= 1'b0;
            full        <= 1'b0;
            done        <= 1'b0;
            dac_sample  <= '0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            ram_we      <= 1'b0;
            ram_rd_req  <= 1'b0;
            ram_rd_ack  <= 1'b0;
        end else begin
            ram_we     <= 1'b0;
            ram_rd_req <= 1'b0;
            ram_rd_ack <= 1'b0;
            if (eff_valid) pend_valid <= 1'b0;
            if (pend_set) begin
                pend_valid <= 1'b1;
                pend_cmd   <= cmd;
            end
            unique case (1'b1)
                do_play: begin
                    rd_ptr  <= '0;
                    done    <= 1'b0;
                    overrun <= 1'b0;
                end
                do_play_res: overrun <= 1'b0;
                do_rec: begin
                    wr_ptr   <= '0;
                    end_addr <= '0;
                    full     <= 1'b0;
                    overrun  <= 1'b0;
                end
                do_del, do_erase: begin
                    wr_ptr   <= '0;
                    rd_ptr   <= '0;
                    end_addr <= '0;
                    done     <= 1'b0;
                    full     <= 1'b0;
                    overrun  <= 1'b0;
                end
                do_pause:  resume_mode <= state;
                do_resume: ;
                default: begin
                    case (state)
                        S_REC_WAIT:
                            if (sample_end) begin
                                ram_wdata <= adc_sample;
                                ram_addr  <= wr_ptr;
                            end
                        S_REC_WRITE: begin
                            if (sample_end) overrun <= 1'b1;
                            if (ram_rdy) begin
                                ram_we   <= 1'b1;
                                end_addr <= wr_ptr + ADDR_ONE;
                                if (wr_last) full   <= 1'b1;
                                else         wr_ptr <= wr_ptr + ADDR_ONE;
                            end
                        end
                        S_PLAY_WAIT:
                            if (sample_end) begin
                                if (rd_last) begin
                                    done       <= 1'b1;
                                    dac_sample <= '0;
                                end else begin
                                    ram_addr <= rd_ptr;
                                end
                            end
                        S_PLAY_REQ: begin
                            if (sample_end) overrun <= 1'b1;
                            if (ram_rdy) ram_rd_req <= 1'b1;
                        end
                        S_PLAY_DATA: begin
                            if (sample_end) overrun <= 1'b1;
                            if (ram_data_present) begin
                                dac_sample <= ram_rdata;
                                ram_rd_ack <= 1'b1;
                                rd_ptr     <= rd_ptr + ADDR_ONE;
                            end
                        end
                        // wr_ptr doubles as the sweep address while erasing
                        S_ERASE:
                            if (ram_rdy) begin
                                ram_we    <= 1'b1;
                                ram_addr  <= wr_ptr;
                                ram_wdata <= '0;
                                wr_ptr    <= wr_last ? '0 : wr_ptr + ADDR_ONE;
                            end
                        default: ;
                    endcase
                end
            endcase
        end
    end

endmodule

// File: tb/tb_audio_ram_sequencer.sv
// Bench for audio_ram_sequencer: RAM model plus sample-queue reference
// for record, playback, pause, overrun, latched commands and erase.
`timescale 1ns/1ps
module tb_audio_ram_sequencer;

    localparam int AW  = 26;
    localparam int DW  = 16;
    localparam int GAP = 10;
    localparam logic [2:0] C_PLAY  = 3'd0;
    localparam logic [2:0] C_REC   = 3'd1;
    localparam logic [2:0] C_PAUSE = 3'd3;
    localparam logic [2:0] C_DALL  = 3'd4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [2:0]    cmd = '0;
    logic          sample_end = 1'b0;
    logic [DW-1:0] adc_sample = '0;
    logic [DW-1:0] dac_sample;
    logic [AW-1:0] max_ram_address = AW'(63);
    logic          ram_rdy = 1'b1;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata;
    logic          ram_we, ram_rd_req, ram_rd_ack;
    logic [DW-1:0] ram_rdata = '0;
    logic          ram_data_present = 1'b0;
    logic [7:0]    status;

    audio_ram_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd(cmd),
        .sample_end(sample_end), .adc_sample(adc_sample),
        .dac_sample(dac_sample), .max_ram_address(max_ram_address),
        .ram_rdy(ram_rdy), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_we(ram_we), .ram_rd_req(ram_rd_req), .ram_rdata(ram_rdata),
        .ram_data_present(ram_data_present), .ram_rd_ack(ram_rd_ack),
        .status(status)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    logic [DW-1:0] mem [0:255];
    int            wr_addr_q[$];
    logic [DW-1:0] wr_data_q[$];
    int            rd_addr_q[$];
    logic [DW-1:0] dac_q[$];
    logic [DW-1:0] smp[$];
    int ex_err = 0;
    int resp_timeout = 0;
    int rd_dmin = 0;
    int rd_dmax = 2;
    int resp_d, resp_n;

    // Bus monitor: logs every pulse seen away from the clock edge.
    initial forever begin
        @(negedge clk);
        if (ram_we) begin
            wr_addr_q.push_back(int'(ram_addr));
            wr_data_q.push_back(ram_wdata);
            mem[ram_addr[7:0]] = ram_wdata;
        end
        if (ram_rd_req) rd_addr_q.push_back(int'(ram_addr));
        if (ram_rd_ack) dac_q.push_back(dac_sample);
        if (int'(ram_we) + int'(ram_rd_req) + int'(ram_rd_ack) > 1) ex_err++;
    end

    // RAM read responder with random latency.
    initial forever begin
        @(negedge clk);
        if (ram_rd_req) begin
            resp_d = $urandom_range(rd_dmax, rd_dmin);
            repeat (resp_d) @(negedge clk);
            ram_rdata = mem[ram_addr[7:0]];
            ram_data_present = 1'b1;
            resp_n = 0;
            do begin
                @(negedge clk);
                resp_n++;
            end while (!ram_rd_ack && resp_n < 20);
            if (!ram_rd_ack) resp_timeout++;
            ram_data_present = 1'b0;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic clear_logs();
        wr_addr_q.delete();
        wr_data_q.delete();
        rd_addr_q.delete();
        dac_q.delete();
    endtask

    task automatic pulse_cmd(input logic [2:0] c);
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd = c;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic send_sample(input logic [DW-1:0] d);
        @(negedge clk);
        sample_end = 1'b1;
        adc_sample = d;
        @(negedge clk);
        sample_end = 1'b0;
        repeat (GAP) @(negedge clk);
    endtask

    task automatic fill_random(input int n);
        smp.delete();
        for (int i = 0; i < n; i++) smp.push_back(DW'($urandom));
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_cmp++;
        if (status !== 8'h00) begin
            n_bad++;
            $display("FAIL reset_status got %h want 00", status);
        end
        n_cmp++;
        if ({ram_we, ram_rd_req, ram_rd_ack} !== 3'b000) begin
            n_bad++;
            $display("FAIL reset_pulses got %b want 000",
                     {ram_we, ram_rd_req, ram_rd_ack});
        end
        n_cmp++;
        if (ram_addr !== '0 || ram_wdata !== '0 || dac_sample !== '0) begin
            n_bad++;
            $display("FAIL reset_data got addr=%h wdata=%h dac=%h want 0",
                     ram_addr, ram_wdata, dac_sample);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++;
        if (status !== 8'h00) begin
            n_bad++;
            $display("FAIL post_reset_status got %h want 00", status);
        end
    endtask

    task automatic test_record_play(input string tag);
        int n = smp.size();
        int errs = 0;
        clear_logs();
        pulse_cmd(C_REC);
        n_cmp++;
        if (status[2:0] !== 3'd1) begin
            n_bad++;
            $display("FAIL %s rec_mode got %0d want 1", tag, status[2:0]);
        end
        foreach (smp[i]) send_sample(smp[i]);
        if (wr_addr_q.size() != n) errs++;
        else foreach (smp[i])
            if (wr_addr_q[i] != i || wr_data_q[i] !== smp[i]) errs++;
        n_cmp++;
        if (errs != 0) begin
            n_bad++;
            $display("FAIL %s rec_writes got %0d writes (%0d bad) want %0d",
                     tag, wr_addr_q.size(), errs, n);
        end
        clear_logs();
        pulse_cmd(C_PLAY);
        n_cmp++;
        if (status[2:0] !== 3'd3) begin
            n_bad++;
            $display("FAIL %s play_mode got %0d want 3", tag, status[2:0]);
        end
        for (int i = 0; i < n; i++) send_sample(DW'($urandom));
        errs = 0;
        if (dac_q.size() != n || rd_addr_q.size() != n) errs++;
        else foreach (smp[i])
            if (dac_q[i] !== smp[i] || rd_addr_q[i] != i) errs++;
        n_cmp++;
        if (errs != 0) begin
            n_bad++;
            $display("FAIL %s playback got %0d samples (%0d bad) want %0d",
                     tag, dac_q.size(), errs, n);
        end
        n_cmp++;
        if (status[5] !== 1'b0) begin
            n_bad++;
            $display("FAIL %s early_done got %b want 0", tag, status[5]);
        end
        send_sample(DW'($urandom));
        n_cmp++;
        if (status[5] !== 1'b1 || status[2:0] !== 3'd0) begin
            n_bad++;
            $display("FAIL %s done got done=%b mode=%0d want done=1 mode=0",
                     tag, status[5], status[2:0]);
        end
        n_cmp++;
        if (dac_sample !== '0 || status[7] !== 1'b0) begin
            n_bad++;
            $display("FAIL %s end_state got dac=%h ovr=%b want 0 0",
                     tag, dac_sample, status[7]);
        end
    endtask

    task automatic test_full();
        int errs = 0;
        max_ram_address = AW'(3);
        fill_random(6);
        clear_logs();
        pulse_cmd(C_REC);
        foreach (smp[i]) send_sample(smp[i]);
        if (wr_addr_q.size() != 4) errs++;
        else for (int i = 0; i < 4; i++)
            if (wr_addr_q[i] != i || wr_data_q[i] !== smp[i]) errs++;
        n_cmp++;
        if (errs != 0) begin
            n_bad++;
            $display("FAIL full_writes got %0d writes (%0d bad) want 4",
                     wr_addr_q.size(), errs);
        end
        n_cmp++;
        if (status[6] !== 1'b1 || status[2:0] !== 3'd0 || status[4] !== 1'b0) begin
            n_bad++;
            $display("FAIL full_status got %h want full=1 idle", status);
        end
        clear_logs();
        pulse_cmd(C_PLAY);
        for (int i = 0; i < 4; i++) send_sample(DW'($urandom));
        errs = 0;
        if (dac_q.size() != 4) errs++;
        else for (int i = 0; i < 4; i++) if (dac_q[i] !== smp[i]) errs++;
        send_sample(DW'($urandom));
        n_cmp++;
        if (errs != 0 || status[5] !== 1'b1) begin
            n_bad++;
            $display("FAIL full_length got %0d samples done=%b want 4 done=1",
                     dac_q.size(), status[5]);
        end
        max_ram_address = AW'(63);
    endtask

    task automatic test_pause();
        int errs = 0;
        fill_random(6);
        pulse_cmd(C_REC);
        foreach (smp[i]) send_sample(smp[i]);
        pulse_cmd(C_PLAY);
        send_sample(DW'($urandom));
        send_sample(DW'($urandom));
        pulse_cmd(C_PAUSE);
        n_cmp++;
        if (status[2:0] !== 3'd6 || status[3] !== 1'b1 || status[4] !== 1'b0) begin
            n_bad++;
            $display("FAIL pause_status got %h want paused mode 6", status);
        end
        clear_logs();
        for (int i = 0; i < 3; i++) send_sample(DW'($urandom));
        n_cmp++;
        if (rd_addr_q.size() != 0 || dac_sample !== smp[1]) begin
            n_bad++;
            $display("FAIL pause_hold got reads=%0d dac=%h want 0 %h",
                     rd_addr_q.size(), dac_sample, smp[1]);
        end
        pulse_cmd(C_PAUSE);
        n_cmp++;
        if (status[2:0] !== 3'd3) begin
            n_bad++;
            $display("FAIL resume_mode got %0d want 3", status[2:0]);
        end
        for (int i = 0; i < 4; i++) send_sample(DW'($urandom));
        if (rd_addr_q.size() != 4) errs++;
        else for (int i = 0; i < 4; i++)
            if (rd_addr_q[i] != i + 2 || dac_q[i] !== smp[i+2]) errs++;
        n_cmp++;
        if (errs != 0) begin
            n_bad++;
            $display("FAIL resume_play got %0d reads first=%0d (%0d bad) want 4 from 2",
                     rd_addr_q.size(), rd_addr_q.size() > 0 ? rd_addr_q[0] : -1, errs);
        end
        send_sample(DW'($urandom));
        n_cmp++;
        if (status[5] !== 1'b1) begin
            n_bad++;
            $display("FAIL pause_done got %b want 1", status[5]);
        end
    endtask

    task automatic test_overrun();
        logic [DW-1:0] a = DW'($urandom);
        logic [DW-1:0] b = DW'($urandom);
        clear_logs();
        pulse_cmd(C_REC);
        ram_rdy = 1'b0;
        send_sample(a);
        for (int i = 0; i < 3; i++) send_sample(DW'($urandom));
        n_cmp++;
        if (wr_addr_q.size() != 0 || status[2:0] !== 3'd2) begin
            n_bad++;
            $display("FAIL stall got writes=%0d mode=%0d want 0 2",
                     wr_addr_q.size(), status[2:0]);
        end
        n_cmp++;
        if (status[7] !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_flag got %b want 1", status[7]);
        end
        @(negedge clk);
        ram_rdy = 1'b1;
        repeat (2) @(negedge clk);
        send_sample(b);
        n_cmp++;
        if (wr_addr_q.size() != 2 || wr_addr_q[0] != 0 || wr_data_q[0] !== a ||
            wr_addr_q[1] != 1 || wr_data_q[1] !== b) begin
            n_bad++;
            $display("FAIL stall_writes got %0d writes want 2 (addr0=%h addr1=%h)",
                     wr_addr_q.size(), a, b);
        end
        clear_logs();
        pulse_cmd(C_PLAY);
        n_cmp++;
        if (status[7] !== 1'b0) begin
            n_bad++;
            $display("FAIL overrun_clear got %b want 0", status[7]);
        end
        for (int i = 0; i < 3; i++) send_sample(DW'($urandom));
        n_cmp++;
        if (dac_q.size() != 2 || dac_q[0] !== a || dac_q[1] !== b ||
            status[5] !== 1'b1) begin
            n_bad++;
            $display("FAIL stall_play got %0d samples done=%b want 2 done=1",
                     dac_q.size(), status[5]);
        end
    endtask

    task automatic test_latched_play();
        int errs = 0;
        fill_random(4);
        pulse_cmd(C_REC);
        foreach (smp[i]) send_sample(smp[i]);
        clear_logs();
        pulse_cmd(C_PLAY);
        send_sample(DW'($urandom));
        rd_dmin = 4;
        rd_dmax = 4;
        @(negedge clk);
        sample_end = 1'b1;
        @(negedge clk);
        sample_end = 1'b0;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd = C_PLAY;
        @(negedge clk);
        cmd_valid = 1'b0;
        n_cmp++;
        if (status[2:0] !== 3'd5) begin
            n_bad++;
            $display("FAIL latch_hold got mode %0d want 5", status[2:0]);
        end
        repeat (GAP) @(negedge clk);
        rd_dmin = 0;
        rd_dmax = 2;
        n_cmp++;
        if (dac_q.size() != 2 || dac_q[0] !== smp[0] || dac_q[1] !== smp[1] ||
            status[2:0] !== 3'd3) begin
            n_bad++;
            $display("FAIL latch_first got %0d samples mode=%0d want 2 mode=3",
                     dac_q.size(), status[2:0]);
        end
        clear_logs();
        for (int i = 0; i < 4; i++) send_sample(DW'($urandom));
        if (rd_addr_q.size() != 4) errs++;
        else for (int i = 0; i < 4; i++)
            if (rd_addr_q[i] != i || dac_q[i] !== smp[i]) errs++;
        n_cmp++;
        if (errs != 0) begin
            n_bad++;
            $display("FAIL latch_restart got %0d reads first=%0d (%0d bad) want 4 from 0",
                     rd_addr_q.size(), rd_addr_q.size() > 0 ? rd_addr_q[0] : -1, errs);
        end
        send_sample(DW'($urandom));
        n_cmp++;
        if (status[5] !== 1'b1) begin
            n_bad++;
            $display("FAIL latch_done got %b want 1", status[5]);
        end
    endtask

    task automatic test_erase();
        int errs = 0;
        int n = 0;
        max_ram_address = AW'(7);
        fill_random(3);
        pulse_cmd(C_REC);
        foreach (smp[i]) send_sample(smp[i]);
        clear_logs();
        pulse_cmd(C_DALL);
        n_cmp++;
        if (status[2:0] !== 3'd7) begin
            n_bad++;
            $display("FAIL erase_mode got %0d want 7", status[2:0]);
        end
        sample_end = 1'b1;
        @(negedge clk);
        sample_end = 1'b0;
        while (status[2:0] != 3'd0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        n_cmp++;
        if (n >= 40) begin
            n_bad++;
            $display("FAIL erase_timeout got mode %0d want 0", status[2:0]);
        end
        if (wr_addr_q.size() != 8) errs++;
        else for (int i = 0; i < 8; i++)
            if (wr_addr_q[i] != i || wr_data_q[i] !== '0) errs++;
        n_cmp++;
        if (errs != 0) begin
            n_bad++;
            $display("FAIL erase_writes got %0d writes (%0d bad) want 8 zeros",
                     wr_addr_q.size(), errs);
        end
        clear_logs();
        pulse_cmd(C_PLAY);
        send_sample(DW'($urandom));
        n_cmp++;
        if (status[5] !== 1'b1 || rd_addr_q.size() != 0 || dac_sample !== '0) begin
            n_bad++;
            $display("FAIL erase_len got done=%b reads=%0d dac=%h want 1 0 0",
                     status[5], rd_addr_q.size(), dac_sample);
        end
        pulse_cmd(C_DALL);
        repeat (2) @(negedge clk);
        n_cmp++;
        if (ram_we !== 1'b1) begin
            n_bad++;
            $display("FAIL erase_active got we=%b want 1", ram_we);
        end
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if (ram_we !== 1'b0 || ram_addr !== '0 || status !== 8'h00) begin
            n_bad++;
            $display("FAIL async_reset got we=%b addr=%h status=%h want 0",
                     ram_we, ram_addr, status);
        end
        @(negedge clk);
        reset = 1'b0;
        max_ram_address = AW'(63);
        repeat (2) @(negedge clk);
    endtask

    task automatic test_bus_rules();
        n_cmp++;
        if (ex_err != 0) begin
            n_bad++;
            $display("FAIL pulse_exclusive got %0d overlaps want 0", ex_err);
        end
        n_cmp++;
        if (resp_timeout != 0) begin
            n_bad++;
            $display("FAIL read_ack got %0d missing acks want 0", resp_timeout);
        end
    endtask

    initial begin
        test_reset();
        smp = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        test_record_play("fixed");
        for (int k = 0; k < 2; k++) begin
            fill_random($urandom_range(8, 3));
            test_record_play($sformatf("rand%0d", k));
        end
        test_full();
        test_pause();
        test_overrun();
        test_latched_play();
        test_erase();
        test_bus_rules();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
